sirali_kilit_acici: RTL

- Sequential, parametrised successor to the combinational lock opener.
- The user turns a dial of 2^KADRAN_BIT positions with right/left step strobes and confirms positions one at a time.
- After SIFRE_UZUNLUK confirmations the entered digits are compared with the stored combination, and the lock opens or counts a failure.
- Repeated failures trigger a timed lockout. The block sits between the keypad/dial front end and the door actuator.

---
 rtl/sirali_kilit_acici.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/sirali_kilit_acici.sv
// sirali_kilit_acici: sequential combination lock opener.
// The dial is stepped right/left in BEKLE, each onay captures one digit, and
// after SIFRE_UZUNLUK digits a single KARSILASTIR cycle decides open or fail.
// Optional feature macro: KILIT_CEZA_EN (failure counting and timed lockout).
// Without it, every mismatch returns to BEKLE, and ceza/hata_sayisi stay 0.
//
// Handshake: there is no valid/ready pair. hazir is the "ready" of the front
// end, and adim_gecerli/onay are one-cycle strobes. A strobe is consumed only
// in a cycle where hazir is high (state BEKLE). In every other cycle it is dropped.
module sirali_kilit_acici #(
  parameter int KADRAN_BIT    = 3,
  parameter int ADIM_BIT      = 3,
  parameter int SIFRE_UZUNLUK = 3,
  parameter int HATA_LIMIT    = 3,
  parameter int KILIT_SURE    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  adim_gecerli,
  input  logic                                  yon,
  input  logic [ADIM_BIT-1:0]                   adim,
  input  logic                                  onay,
  input  logic                                  kilitle,
  input  logic [SIFRE_UZUNLUK*KADRAN_BIT-1:0]   kilit_sifre,
  output logic                                  hazir,
  output logic [KADRAN_BIT-1:0]                 kadran,
  output logic                                  kilit_acik,
  output logic                                  hata,
  output logic                                  ceza,
  output logic [$clog2(HATA_LIMIT+1)-1:0]       hata_sayisi
);

  localparam int IDX_W   = (SIFRE_UZUNLUK > 1) ? $clog2(SIFRE_UZUNLUK) : 1;
  localparam int TOP_W   = (ADIM_BIT > KADRAN_BIT) ? ADIM_BIT : KADRAN_BIT;
  localparam int SIFRE_W = SIFRE_UZUNLUK * KADRAN_BIT;
  localparam logic [IDX_W-1:0] SON_IDX = IDX_W'(SIFRE_UZUNLUK - 1);

  typedef enum logic [1:0] {
    BEKLE       = 2'd0,
    KARSILASTIR = 2'd1,
    ACIK        = 2'd2,
    CEZA        = 2'd3
  } durum_t;

  durum_t                  durum_q, durum_d;
  logic [KADRAN_BIT-1:0]   kadran_q, kadran_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [SIFRE_W-1:0]      slot_q, slot_d;
  logic                    hata_q, hata_d;

  logic [TOP_W-1:0]        kadran_ek;
  logic [TOP_W-1:0]        adim_ek;
  logic [TOP_W-1:0]        toplam;
  logic [KADRAN_BIT-1:0]   kadran_hamle;

`ifdef KILIT_CEZA_EN
  localparam int HS_W    = $clog2(HATA_LIMIT + 1);
  localparam int SAYAC_W = $clog2(KILIT_SURE + 1);
  logic [HS_W-1:0]         hs_q, hs_d;
  logic [SAYAC_W-1:0]      sayac_q, sayac_d;
`endif

  // Dial position after this cycle's move. The arithmetic runs in the wider
  // of the two widths and is then truncated, so wrap and adim reduction are
  // both plain modulo 2^KADRAN_BIT.
  always_comb begin
    kadran_ek = TOP_W'(kadran_q);
    adim_ek   = TOP_W'(adim);
    if (yon) toplam = kadran_ek - adim_ek;
    else     toplam = kadran_ek + adim_ek;
    if (adim_gecerli) kadran_hamle = toplam[KADRAN_BIT-1:0];
    else              kadran_hamle = kadran_q;
  end

  // Next-state and datapath updates for the lock FSM
  always_comb begin
    durum_d  = durum_q;
    kadran_d = kadran_q;
    idx_d    = idx_q;
    slot_d   = slot_q;
    hata_d   = 1'b0;
`ifdef KILIT_CEZA_EN
    hs_d     = hs_q;
    sayac_d  = sayac_q;
`endif
    case (durum_q)
      BEKLE: begin
        kadran_d = kadran_hamle;
        if (onay) begin
          // A simultaneous move is already folded into kadran_hamle, so the
          // post-move position is stored.
          for (int i = 0; i < SIFRE_UZUNLUK; i++) begin
            if (idx_q == IDX_W'(i)) slot_d[i*KADRAN_BIT +: KADRAN_BIT] = kadran_hamle;
          end
          if (idx_q == SON_IDX) durum_d = KARSILASTIR;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      KARSILASTIR: begin
        kadran_d = '0;
        idx_d    = '0;
        if (slot_q == kilit_sifre) begin
          durum_d = ACIK;
`ifdef KILIT_CEZA_EN
          hs_d    = '0;
`endif
        end else begin
          hata_d = 1'b1;
`ifdef KILIT_CEZA_EN
          hs_d   = hs_q + 1'b1;
          if (hs_q == HS_W'(HATA_LIMIT - 1)) begin
            durum_d = CEZA;
            sayac_d = SAYAC_W'(KILIT_SURE - 1);
          end else begin
            durum_d = BEKLE;
          end
`else
          durum_d = BEKLE;
`endif
        end
      end
      ACIK: begin
        if (kilitle) begin
          durum_d  = BEKLE;
          kadran_d = '0;
        end
      end
      CEZA: begin
`ifdef KILIT_CEZA_EN
        // Counter holds remaining cycles minus one; leave when it hits zero.
        if (sayac_q == '0) begin
          durum_d = BEKLE;
          hs_d    = '0;
        end else begin
          sayac_d = sayac_q - 1'b1;
        end
`else
        durum_d = BEKLE;
`endif
      end
      default: durum_d = BEKLE;
    endcase
  end

  // State and datapath registers; reset discards any partial entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_q  <= BEKLE;
      kadran_q <= '0;
      idx_q    <= '0;
      slot_q   <= '0;
      hata_q   <= 1'b0;
    end else begin
      durum_q  <= durum_d;
      kadran_q <= kadran_d;
      idx_q    <= idx_d;
      slot_q   <= slot_d;
      hata_q   <= hata_d;
    end
  end

`ifdef KILIT_CEZA_EN
  // Failure counter and lockout timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= '0;
      sayac_q <= '0;
    end else begin
      hs_q    <= hs_d;
      sayac_q <= sayac_d;
    end
  end

  assign ceza        = (durum_q == CEZA);
  assign hata_sayisi = hs_q;
`else
  assign ceza        = 1'b0;
  assign hata_sayisi = '0;
`endif

  // All outputs come from registers only
  assign hazir      = (durum_q == BEKLE);
  assign kilit_acik = (durum_q == ACIK);
  assign kadran     = kadran_q;
  assign hata       = hata_q;

endmodule
